// File: rtl/snitch_ro_cache_ctrl.sv
// Register front-end for the Snitch read-only cache: holds the cache enable,
// the cacheable address regions and the flush counter, and sequences flush
// requests to the cache through a two-state IDLE/FLUSH machine.
//
// Flush handshake: flush_valid_o rises when a flush is requested and stays
// high, never dropping on its own, until a cycle in which flush_ready_i is
// also high. That cycle is the handshake, and one flush completes on it.
module snitch_ro_cache_ctrl #(
    parameter int unsigned AxiAddrWidth = 48,
    parameter int unsigned NrAddrRules  = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       reg_valid_i,
    input  logic                                       reg_write_i,
    input  logic [15:0]                                reg_addr_i,
    input  logic [63:0]                                reg_wdata_i,
    output logic                                       reg_ready_o,
    output logic [63:0]                                reg_rdata_o,
    output logic                                       reg_error_o,
    output logic                                       enable_o,
    output logic                                       flush_valid_o,
    input  logic                                       flush_ready_i,
    output logic [NrAddrRules-1:0][AxiAddrWidth-1:0]   start_addr_o,
    output logic [NrAddrRules-1:0][AxiAddrWidth-1:0]   end_addr_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e                                  state_q, state_d;
    logic                                    enable_q, enable_d;
    logic                                    pending_q, pending_d;
    logic [31:0]                             cnt_q, cnt_d;
    logic [NrAddrRules-1:0][AxiAddrWidth-1:0] start_q, end_q;

    logic                   hit_ctrl, hit_flush, hit_cnt, mapped;
    logic [NrAddrRules-1:0] hit_start, hit_end;
    logic                   access_err, wr_ok, rd_ok, trigger, busy;

    // Write data bits above the region width are never stored.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    assign reg_ready_o  = 1'b1;
    assign start_addr_o = start_q;
    assign end_addr_o   = end_q;
    assign busy         = (state_q == ST_FLUSH) || pending_q;

    // Address decode, access legality and flush trigger detection.
    always_comb begin
        hit_ctrl  = (reg_addr_i == 16'h0000);
        hit_flush = (reg_addr_i == 16'h0008);
        hit_cnt   = (reg_addr_i == 16'h0010);
        hit_start = '0;
        hit_end   = '0;
        for (int i = 0; i < int'(NrAddrRules); i++) begin
            hit_start[i] = (reg_addr_i == 16'(32'h20 + 32'(16 * i)));
            hit_end[i]   = (reg_addr_i == 16'(32'h28 + 32'(16 * i)));
        end
        mapped     = hit_ctrl | hit_flush | hit_cnt | (|hit_start) | (|hit_end);
        access_err = reg_valid_i &
                     ((reg_addr_i[2:0] != 3'b000) | ~mapped | (reg_write_i & hit_cnt));
        wr_ok      = reg_valid_i & reg_write_i & ~access_err;
        rd_ok      = reg_valid_i & ~reg_write_i & ~access_err;
        trigger    = wr_ok & ((hit_flush & reg_wdata_i[0]) |
                              (|hit_start) | (|hit_end) |
                              (hit_ctrl & reg_wdata_i[0] & ~enable_q));
    end

    assign reg_error_o = access_err;

    // Read mux; zero whenever the access is not a legal read.
    always_comb begin
        reg_rdata_o = '0;
        if (rd_ok) begin
            if (hit_ctrl)  reg_rdata_o = {63'd0, enable_q};
            if (hit_flush) reg_rdata_o = {63'd0, busy};
            if (hit_cnt)   reg_rdata_o = {32'd0, cnt_q};
            for (int i = 0; i < int'(NrAddrRules); i++) begin
                if (hit_start[i]) reg_rdata_o = 64'(start_q[i]);
                if (hit_end[i])   reg_rdata_o = 64'(end_q[i]);
            end
        end
    end

    // Next-state logic: a handshake with a flush still owed keeps FLUSH high
    // and starts that owed flush, which also covers a trigger in the same cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        enable_d  = enable_q;
        if (wr_ok && hit_ctrl) enable_d = reg_wdata_i[0];
        case (state_q)
            ST_IDLE: begin
                if (trigger) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_ready_i) begin
                    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                    if (pending_q || trigger) pending_d = 1'b0;
                    else                      state_d   = ST_IDLE;
                end else if (trigger) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, control registers and registered cache-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            cnt_q         <= '0;
            enable_q      <= 1'b0;
            flush_valid_o <= 1'b0;
            enable_o      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            enable_q      <= enable_d;
            flush_valid_o <= (state_d == ST_FLUSH);
            enable_o      <= enable_d && (state_d == ST_IDLE);
        end
    end

    // Cacheable region registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q <= '0;
            end_q   <= '0;
        end else begin
            for (int i = 0; i < int'(NrAddrRules); i++) begin
                if (wr_ok && hit_start[i]) start_q[i] <= reg_wdata_i[AxiAddrWidth-1:0];
                if (wr_ok && hit_end[i])   end_q[i]   <= reg_wdata_i[AxiAddrWidth-1:0];
            end
        end
    end

endmodule

// File: doc/snitch_ro_cache_ctrl.md
SNITCH_RO_CACHE_CTRL -- requirements
Module: snitch_ro_cache_ctrl

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 48: width of the cacheable-region address outputs, at most 64.
REQ-002 SHALL have parameter NrAddrRules, default 1: number of cacheable regions, at least 1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port reg_valid_i, input, 1 bit: register access request.
REQ-006 SHALL have port reg_write_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port reg_addr_i, input, 16 bits: byte address.
REQ-008 SHALL have port reg_wdata_i, input, 64 bits: write data.
REQ-009 SHALL have port reg_ready_o, output, 1 bit: held at 1; every access completes in its request cycle.
REQ-010 SHALL have port reg_rdata_o, output, 64 bits: combinational read data.
REQ-011 SHALL have port reg_error_o, output, 1 bit: combinational access error.
REQ-012 SHALL have port enable_o, output, 1 bit: cache enable to the read-only cache.
REQ-013 SHALL have port flush_valid_o, output, 1 bit: flush request to the cache.
REQ-014 SHALL have port flush_ready_i, input, 1 bit: flush acknowledge from the cache.
REQ-015 SHALL have port start_addr_o, output, NrAddrRules x AxiAddrWidth bits: region start addresses.
REQ-016 SHALL have port end_addr_o, output, NrAddrRules x AxiAddrWidth bits: region end addresses.

Function
REQ-017 Register map SHALL be:
- 0x00 CTRL: bit0 = enable, read/write.
- 0x08 FLUSH: writing bit0 = 1 requests a flush; reading returns bit0 = busy, where busy = (state==FLUSH) or pending.
- 0x10 FLUSH_CNT: read-only; 32-bit count of completed flushes, zero-extended.
- 0x20+16*i START[i] and 0x28+16*i END[i]: read/write.
REQ-018 START and END writes SHALL store wdata[AxiAddrWidth-1:0]; reads SHALL return the stored value zero-extended.
REQ-019 An access SHALL set reg_error_o = 1, return reg_rdata_o = 0, and change no state if any of the following holds:
- reg_addr_i[2:0] != 0;
- the address is unmapped (including 0x18, and rule index >= NrAddrRules);
- the access is a write to FLUSH_CNT.
REQ-020 A flush trigger SHALL be any one of:
- an accepted write to FLUSH with bit0 = 1;
- any accepted START or END write;
- a CTRL write that changes enable from 0 to 1.
REQ-021 The FSM SHALL have two states, IDLE and FLUSH.
- In FLUSH, flush_valid_o = 1; in IDLE, flush_valid_o = 0.
REQ-022 IDLE SHALL go to FLUSH on the edge that ends a trigger cycle, so flush_valid_o = 1 on the cycle after the trigger.
REQ-023 In FLUSH, on a handshake (flush_ready_i = 1):
- FLUSH_CNT SHALL increment;
- if pending = 1, the FSM SHALL stay in FLUSH, flush_valid_o SHALL remain 1, and pending SHALL clear;
- otherwise the FSM SHALL go to IDLE.
REQ-024 A trigger while in FLUSH SHALL set pending. Multiple triggers during one flush SHALL coalesce into one further flush.
REQ-025 A trigger in the same cycle as a handshake SHALL set pending, so exactly one further flush follows.
REQ-026 flush_valid_o SHALL NOT deassert before flush_ready_i is seen.
REQ-027 enable_o SHALL equal CTRL.enable AND (state == IDLE), so new requests bypass the cache while a flush is outstanding.
REQ-028 FLUSH_CNT SHALL saturate at 0xFFFF_FFFF.
REQ-029 start_addr_o and end_addr_o SHALL be driven directly from their registers. An update is visible on the cycle after the write.
REQ-030 Reads SHALL have no side effects.
REQ-031 Inputs SHALL be ignored when reg_valid_i = 0, and reg_error_o SHALL be 0 in that case.

Reset
REQ-032 While rst_ni = 0, the following SHALL be forced asynchronously:
- CTRL.enable = 0, pending = 0, FLUSH_CNT = 0, all START/END = 0, state = IDLE;
- enable_o = 0 and flush_valid_o = 0.
REQ-033 Reset asserted during FLUSH SHALL abandon the flush without incrementing FLUSH_CNT.
REQ-034 After release, no flush SHALL start without a trigger.

Verification
REQ-035 Reset then read every register -> all read 0, error 0; read 0x18 -> error 1, rdata 0; read 0x04 -> error 1.
REQ-036 Write CTRL = 1 at cycle t with flush_ready_i = 0 for 3 cycles, then 1:
- flush_valid_o = 1 from t+1 until the handshake;
- enable_o = 0 until the cycle after the handshake, then 1;
- FLUSH_CNT = 1.
REQ-037 During a flush, write START[0] = 0x8000_0000 and then END[0] = 0x8010_0000:
- exactly two handshakes in total;
- flush_valid_o stays 1 across both;
- FLUSH_CNT = 2;
- start_addr_o[0] = 0x8000_0000.
REQ-038 Write FLUSH = 1 in the same cycle as a handshake -> one additional flush; busy reads 1 until it completes.
REQ-039 Assert rst_ni = 0 mid-flush -> flush_valid_o and enable_o drop immediately; FLUSH_CNT = 0.
REQ-040 Write FLUSH_CNT -> error 1 and value unchanged; write with address >= 0x20+16*NrAddrRules -> error 1.
